// File: rtl/ngram_encoder.sv
// Temporal n-gram encoder: binds the incoming spatial hypervector with
// progressively rotated copies of the previous NGRAM_SIZE-1 samples and
// presents the result to the associative memory over a Valid/Ready port.
module ngram_encoder #(
    parameter int unsigned HV_DIMENSION = 2000,
    parameter int unsigned NGRAM_SIZE   = 3
) (
    input  logic                     Clk_CI,
    input  logic                     Reset_RBI,
    input  logic                     Flush_SI,
    input  logic                     ValidIn_SI,
    output logic                     ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1]  HypervectorIn_DI,
    output logic                     ValidOut_SO,
    input  logic                     ReadyIn_SI,
    output logic [0:HV_DIMENSION-1]  HypervectorOut_DO
);

    localparam int unsigned FILL_W     = $clog2(NGRAM_SIZE + 1);
    localparam int unsigned HIST_DEPTH = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
    localparam int unsigned HIST_W     = HIST_DEPTH * HV_DIMENSION;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NGRAM_SIZE);

    typedef enum logic {
        ST_IDLE          = 1'b0,
        ST_OUTPUT_STABLE = 1'b1
    } state_e;

    state_e                    r_state;
    state_e                    w_state_next;
    logic [FILL_W-1:0]         r_fill;
    logic [FILL_W-1:0]         w_fill_inc;
    logic [0:HV_DIMENSION-1]   r_out;
    logic [0:HV_DIMENSION-1]   w_ngram;
    logic [0:HV_DIMENSION-1]   w_rot_acc;
    logic                      w_accept;
    logic                      w_load;

    // rho: rotate right by one position in big-endian bit numbering
    function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] x);
        return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
    endfunction

    // Saturating post-increment fill value used for the warm-up decision
    always_comb begin
        w_fill_inc = r_fill;
        if (r_fill != FILL_MAX) begin
            w_fill_inc = r_fill + 1'b1;
        end
    end

    // History shift register and rotated-history accumulation
    generate
        if (NGRAM_SIZE > 1) begin : g_hist
            // H[1] occupies the leftmost HV_DIMENSION bits, H[k] the k-th slot
            logic [0:HIST_W-1]       r_hist;
            logic [0:HV_DIMENSION-1] w_acc [1:NGRAM_SIZE];

            // Shift history on accept; flush clears it
            always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
                if (!Reset_RBI) begin
                    r_hist <= '0;
                end else if (Flush_SI) begin
                    r_hist <= '0;
                end else if (w_accept) begin
                    r_hist <= HIST_W'({HypervectorIn_DI, r_hist} >> HV_DIMENSION);
                end
            end

            // Horner chain: w_acc[1] = sum over k of rho^k(H[k])
            assign w_acc[NGRAM_SIZE] = '0;
            for (genvar k = 1; k < NGRAM_SIZE; k++) begin : g_acc
                assign w_acc[k] = rho(w_acc[k+1] ^ r_hist[(k-1)*HV_DIMENSION +: HV_DIMENSION]);
            end
            assign w_rot_acc = w_acc[1];
        end else begin : g_no_hist
            assign w_rot_acc = '0;
        end
    endgenerate

    // N-gram from the incoming sample and pre-shift history
    always_comb begin
        w_ngram = HypervectorIn_DI ^ w_rot_acc;
    end

    // FSM state register
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state, handshake outputs and datapath enables
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        ReadyOut_SO  = 1'b0;
        ValidOut_SO  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ReadyOut_SO = 1'b1;
                if (ValidIn_SI && !Flush_SI) begin
                    w_accept = 1'b1;
                    if (w_fill_inc == FILL_MAX) begin
                        w_load       = 1'b1;
                        w_state_next = ST_OUTPUT_STABLE;
                    end
                end
            end
            ST_OUTPUT_STABLE: begin
                ValidOut_SO = 1'b1;
                if (ReadyIn_SI) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (Flush_SI) begin
            w_state_next = ST_IDLE;
        end
    end

    // Fill counter and output register; flush wins over accept
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            r_fill <= '0;
            r_out  <= '0;
        end else if (Flush_SI) begin
            r_fill <= '0;
            r_out  <= '0;
        end else if (w_accept) begin
            r_fill <= w_fill_inc;
            if (w_load) begin
                r_out <= w_ngram;
            end
        end
    end

    assign HypervectorOut_DO = r_out;

endmodule

// File: tb/tb_ngram_encoder.sv
// Self-checking bench for ngram_encoder with HV_DIMENSION=8, NGRAM_SIZE=3.
module tb_ngram_encoder;

    localparam int D = 8;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         vin;
    logic         rdy_out;
    logic [0:D-1] hv_in;
    logic         vout;
    logic         rdy_in;
    logic [0:D-1] hv_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ngram_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(N)) dut (
        .Clk_CI            (clk),
        .Reset_RBI         (rst_n),
        .Flush_SI          (flush),
        .ValidIn_SI        (vin),
        .ReadyOut_SO       (rdy_out),
        .HypervectorIn_DI  (hv_in),
        .ValidOut_SO       (vout),
        .ReadyIn_SI        (rdy_in),
        .HypervectorOut_DO (hv_out)
    );

    typedef struct {
        logic       v;
        logic       r;
        logic       f;
        logic [7:0] d;
        logic       ev;
        logic       erdy;
        logic [7:0] eo;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    logic [7:0] m_hist[$];
    int         m_fill;
    bit         m_pend;
    logic [7:0] m_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rotr(input logic [7:0] x, input int k);
        logic [15:0] t;
        t = {x, x} >> (k % 8);
        return t[7:0];
    endfunction

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i < N - 1; i++) m_hist.push_back(8'h00);
        m_fill = 0;
        m_pend = 1'b0;
        m_out  = 8'h00;
    endtask

    task automatic model_step(input logic v, input logic r, input logic f, input logic [7:0] d);
        logic [7:0] ng;
        if (f) begin
            model_reset();
        end else if (!m_pend && v) begin
            ng = d;
            for (int k = 1; k < N; k++) ng ^= rotr(m_hist[k-1], k);
            if (N > 1) begin
                m_hist.push_front(d);
                void'(m_hist.pop_back());
            end
            if (m_fill < N) m_fill++;
            if (m_fill == N) begin
                m_out  = ng;
                m_pend = 1'b1;
            end
        end else if (m_pend && r) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic f, input logic [7:0] d);
        vin    = v;
        rdy_in = r;
        flush  = f;
        hv_in  = d;
    endtask

    task automatic run_cycle(input string tag, input logic v, input logic r, input logic f, input logic [7:0] d);
        model_step(v, r, f, d);
        drive(v, r, f, d);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(vout), 32'(m_pend));
        check({tag, "_ready"}, 32'(rdy_out), 32'(!m_pend));
        check({tag, "_out"}, 32'(hv_out), 32'(m_out));
    endtask

    task automatic async_reset(input string tag);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        #3;
        rst_n = 1'b0;
        #1;
        check({tag, "_valid"}, 32'(vout), 32'd0);
        check({tag, "_ready"}, 32'(rdy_out), 32'd1);
        check({tag, "_out"}, 32'(hv_out), 32'd0);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        model_reset();

        // Directed vectors: {v, r, f, d, expected valid, expected ready, expected out}
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 8'hE0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h60});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h60});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 8'hC0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'hBB, 1'b1, 1'b0, 8'hC0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'hCC, 1'b1, 1'b0, 8'hC0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'hDD, 1'b1, 1'b0, 8'hC0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 8'hC0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 8'hC0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'h51});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 8'h45});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h45});

        #12;
        check("reset_valid", 32'(vout), 32'd0);
        check("reset_ready", 32'(rdy_out), 32'd1);
        check("reset_out", 32'(hv_out), 32'd0);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].d);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(vout), 32'(tbl[i].ev));
            check($sformatf("vec%0d_ready", i), 32'(rdy_out), 32'(tbl[i].erdy));
            check($sformatf("vec%0d_out", i), 32'(hv_out), 32'(tbl[i].eo));
        end

        // Re-synchronise the model through a flush, then reset while an output is pending
        run_cycle("sync_flush", 1'b0, 1'b0, 1'b1, 8'h00);
        run_cycle("pend_a0", 1'b1, 1'b0, 1'b0, 8'h3C);
        run_cycle("pend_a1", 1'b1, 1'b0, 1'b0, 8'h96);
        run_cycle("pend_a2", 1'b1, 1'b0, 1'b0, 8'h5A);
        async_reset("rst_in_output");

        // Reset in the middle of warm-up, then a full warm-up is required again
        run_cycle("warm_a0", 1'b1, 1'b0, 1'b0, 8'h81);
        run_cycle("warm_a1", 1'b1, 1'b0, 1'b0, 8'h42);
        async_reset("rst_in_warmup");
        run_cycle("post_rst_a0", 1'b1, 1'b0, 1'b0, 8'h24);
        run_cycle("post_rst_a1", 1'b1, 1'b0, 1'b0, 8'h18);
        run_cycle("post_rst_a2", 1'b1, 1'b1, 1'b0, 8'hF0);
        check("post_rst_fires", 32'(vout), 32'd1);

        // Randomised traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            run_cycle($sformatf("rnd%0d", c),
                      logic'($urandom_range(0, 3) != 0),
                      logic'($urandom_range(0, 1)),
                      logic'($urandom_range(0, 24) == 0),
                      8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
